// File: rtl/issue_queue_pkg.sv
// Shared types and default sizes for the issue queue slice.
// Optional feature macro: IQ_WAKEUP_BYPASS_EN (same-cycle wakeup to issue).
package issue_queue_pkg;

  localparam int IQ_DEPTH         = 4;
  localparam int IQ_ROB_IDX_WIDTH = 5;
  localparam int IQ_NUM_CDB       = 4;
  localparam int IQ_DATA_WIDTH    = 32;
  localparam int IQ_PAYLOAD_WIDTH = 96;

  // One waiting instruction at the default configuration.
  typedef struct packed {
    logic                        valid;
    logic                        rs1_ready;
    logic [IQ_DATA_WIDTH-1:0]    rs1_data;
    logic [IQ_ROB_IDX_WIDTH-1:0] rs1_rob_idx;
    logic                        rs2_ready;
    logic [IQ_DATA_WIDTH-1:0]    rs2_data;
    logic [IQ_ROB_IDX_WIDTH-1:0] rs2_rob_idx;
    logic [IQ_ROB_IDX_WIDTH-1:0] rd_rob_idx;
    logic [IQ_PAYLOAD_WIDTH-1:0] payload;
  } iq_entry_t;

  // One CDB broadcast channel at the default configuration.
  typedef struct packed {
    logic                        valid;
    logic [IQ_ROB_IDX_WIDTH-1:0] rob_idx;
    logic [IQ_DATA_WIDTH-1:0]    data;
  } cdb_chan_t;

endpackage

// File: rtl/iq_age_select.sv
// Age matrix plus oldest-eligible grant. older_q[i][j]=1 means slot i was
// allocated before slot j, so age is independent of slot index.
module iq_age_select
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] free_oh,
  input  logic [DEPTH-1:0] eligible,
  output logic [DEPTH-1:0] grant_oh
);

  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  // Next age state: a new entry is younger than every other slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) older_d[i] = older_q[i];
    for (int i = 0; i < DEPTH; i++) begin
      if (free_oh[i]) older_d[i] = '0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (alloc_oh[k]) begin
        older_d[k] = '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != k) older_d[j][k] = 1'b1;
        end
      end
    end
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
    end
  end

  // Grant the eligible slot that no other eligible slot is older than.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      grant_oh[i] = eligible[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && eligible[j] && older_q[j][i]) grant_oh[i] = 1'b0;
      end
    end
  end

  // Age matrix register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) older_q[i] <= '0;
      else     older_q[i] <= older_d[i];
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Multi-entry issue queue between dispatch and one functional unit.
// Operands wake by ROB tag from NUM_CDB channels; oldest ready entry issues.
// Optional feature macro: IQ_WAKEUP_BYPASS_EN (entry woken this cycle may
// issue this cycle with operand data muxed from the CDB).
// Handshakes: a transfer happens on a clock edge where valid && ready are
// both high; valid never depends on ready, alloc_ready depends only on
// registered occupancy.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH         = IQ_DEPTH,
  parameter int ROB_IDX_WIDTH = IQ_ROB_IDX_WIDTH,
  parameter int NUM_CDB       = IQ_NUM_CDB,
  parameter int DATA_WIDTH    = IQ_DATA_WIDTH,
  parameter int PAYLOAD_WIDTH = IQ_PAYLOAD_WIDTH,
  localparam int OCC_W        = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  input  logic [PAYLOAD_WIDTH-1:0]         alloc_payload,
  input  logic [ROB_IDX_WIDTH-1:0]         alloc_rd_rob_idx,
  input  logic                             alloc_rs1_ready,
  input  logic [DATA_WIDTH-1:0]            alloc_rs1_data,
  input  logic [ROB_IDX_WIDTH-1:0]         alloc_rs1_rob_idx,
  input  logic                             alloc_rs2_ready,
  input  logic [DATA_WIDTH-1:0]            alloc_rs2_data,
  input  logic [ROB_IDX_WIDTH-1:0]         alloc_rs2_rob_idx,
  input  logic [NUM_CDB-1:0]               cdb_valid,
  input  logic [NUM_CDB*ROB_IDX_WIDTH-1:0] cdb_rob_idx,
  input  logic [NUM_CDB*DATA_WIDTH-1:0]    cdb_data,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [PAYLOAD_WIDTH-1:0]         issue_payload,
  output logic [DATA_WIDTH-1:0]            issue_rs1_data,
  output logic [DATA_WIDTH-1:0]            issue_rs2_data,
  output logic [ROB_IDX_WIDTH-1:0]         issue_rd_rob_idx,
  output logic [OCC_W-1:0]                 occupancy
);

  // Same shape as iq_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic                     valid;
    logic                     rs1_ready;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [ROB_IDX_WIDTH-1:0] rs1_rob_idx;
    logic                     rs2_ready;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [ROB_IDX_WIDTH-1:0] rs2_rob_idx;
    logic [ROB_IDX_WIDTH-1:0] rd_rob_idx;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];

  logic [DEPTH-1:0] rs1_hit, rs2_hit, eligible, grant_oh, alloc_oh, free_oh;
  logic [DATA_WIDTH-1:0] rs1_cdb [DEPTH];
  logic [DATA_WIDTH-1:0] rs2_cdb [DEPTH];
  logic [DATA_WIDTH-1:0] rs1_now [DEPTH];
  logic [DATA_WIDTH-1:0] rs2_now [DEPTH];
  logic                  a1_hit, a2_hit, alloc_fire, issue_fire;
  logic [DATA_WIDTH-1:0] a1_cdb, a2_cdb;

  // {hit, data} of the lowest-index valid CDB channel carrying tag.
  function automatic logic [DATA_WIDTH:0] snoop(
    input logic [ROB_IDX_WIDTH-1:0]         tag,
    input logic [NUM_CDB-1:0]               cv,
    input logic [NUM_CDB*ROB_IDX_WIDTH-1:0] ct,
    input logic [NUM_CDB*DATA_WIDTH-1:0]    cd
  );
    logic [DATA_WIDTH:0] r;
    r = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cv[c] && ct[c*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == tag)
        r = {1'b1, cd[c*DATA_WIDTH +: DATA_WIDTH]};
    end
    return r;
  endfunction

  // Tag compare of every waiting operand and of the incoming alloc.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {rs1_hit[i], rs1_cdb[i]} = snoop(ent_q[i].rs1_rob_idx, cdb_valid, cdb_rob_idx, cdb_data);
      {rs2_hit[i], rs2_cdb[i]} = snoop(ent_q[i].rs2_rob_idx, cdb_valid, cdb_rob_idx, cdb_data);
    end
    {a1_hit, a1_cdb} = snoop(alloc_rs1_rob_idx, cdb_valid, cdb_rob_idx, cdb_data);
    {a2_hit, a2_cdb} = snoop(alloc_rs2_rob_idx, cdb_valid, cdb_rob_idx, cdb_data);
  end

  // Eligibility and the operand values presented if selected.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef IQ_WAKEUP_BYPASS_EN
      eligible[i] = ent_q[i].valid && (ent_q[i].rs1_ready || rs1_hit[i])
                                   && (ent_q[i].rs2_ready || rs2_hit[i]);
      rs1_now[i]  = ent_q[i].rs1_ready ? ent_q[i].rs1_data : rs1_cdb[i];
      rs2_now[i]  = ent_q[i].rs2_ready ? ent_q[i].rs2_data : rs2_cdb[i];
`else
      eligible[i] = ent_q[i].valid && ent_q[i].rs1_ready && ent_q[i].rs2_ready;
      rs1_now[i]  = ent_q[i].rs1_data;
      rs2_now[i]  = ent_q[i].rs2_data;
`endif
    end
  end

  // Occupancy, alloc slot choice and the handshakes.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(ent_q[i].valid);
    alloc_ready = (occupancy < OCC_W'(DEPTH));
    alloc_fire  = alloc_valid && alloc_ready && !flush;
    alloc_oh    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        alloc_oh    = '0;
        alloc_oh[i] = alloc_fire;
      end
    end
    issue_valid = (|grant_oh) && !flush && !rst;
    issue_fire  = issue_valid && issue_ready;
    free_oh     = issue_fire ? grant_oh : '0;
  end

  // Issue mux: OR of the granted entry, zero when nothing is presented.
  always_comb begin
    issue_payload    = '0;
    issue_rs1_data   = '0;
    issue_rs2_data   = '0;
    issue_rd_rob_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant_oh[i] && issue_valid) begin
        issue_payload    = issue_payload    | ent_q[i].payload;
        issue_rs1_data   = issue_rs1_data   | rs1_now[i];
        issue_rs2_data   = issue_rs2_data   | rs2_now[i];
        issue_rd_rob_idx = issue_rd_rob_idx | ent_q[i].rd_rob_idx;
      end
    end
  end

  // Next entry state: wakeup, free on issue, write on alloc; flush wins.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid && !ent_q[i].rs1_ready && rs1_hit[i]) begin
        ent_d[i].rs1_ready = 1'b1;
        ent_d[i].rs1_data  = rs1_cdb[i];
      end
      if (ent_q[i].valid && !ent_q[i].rs2_ready && rs2_hit[i]) begin
        ent_d[i].rs2_ready = 1'b1;
        ent_d[i].rs2_data  = rs2_cdb[i];
      end
      if (free_oh[i]) ent_d[i].valid = 1'b0;
      if (alloc_oh[i]) begin
        ent_d[i].valid       = 1'b1;
        ent_d[i].rs1_ready   = alloc_rs1_ready || a1_hit;
        ent_d[i].rs1_data    = alloc_rs1_ready ? alloc_rs1_data : a1_cdb;
        ent_d[i].rs1_rob_idx = alloc_rs1_rob_idx;
        ent_d[i].rs2_ready   = alloc_rs2_ready || a2_hit;
        ent_d[i].rs2_data    = alloc_rs2_ready ? alloc_rs2_data : a2_cdb;
        ent_d[i].rs2_rob_idx = alloc_rs2_rob_idx;
        ent_d[i].rd_rob_idx  = alloc_rd_rob_idx;
        ent_d[i].payload     = alloc_payload;
      end
      if (flush) ent_d[i].valid = 1'b0;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) ent_q[i] <= '0;
      else     ent_q[i] <= ent_d[i];
    end
  end

  iq_age_select #(.DEPTH(DEPTH)) u_age (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .alloc_oh (alloc_oh),
    .free_oh  (free_oh),
    .eligible (eligible),
    .grant_oh (grant_oh)
  );

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus random traffic
// against an age-ordered list model. Honours IQ_WAKEUP_BYPASS_EN.
module tb_issue_queue;

  localparam int DEPTH = 4, RW = 5, NC = 4, DW = 32, PW = 96;
  localparam int W = PW + DW + DW + RW;
`ifdef IQ_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk, rst, flush, alloc_valid, alloc_ready, issue_valid, issue_ready;
  logic [PW-1:0] alloc_payload, issue_payload;
  logic [RW-1:0] alloc_rd_rob_idx, alloc_rs1_rob_idx, alloc_rs2_rob_idx, issue_rd_rob_idx;
  logic alloc_rs1_ready, alloc_rs2_ready;
  logic [DW-1:0] alloc_rs1_data, alloc_rs2_data, issue_rs1_data, issue_rs2_data;
  logic [NC-1:0] cdb_valid;
  logic [NC*RW-1:0] cdb_rob_idx;
  logic [NC*DW-1:0] cdb_data;
  logic [2:0] occupancy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic r1, r2;
    logic [DW-1:0] d1, d2;
    logic [RW-1:0] t1, t2, rd;
    logic [PW-1:0] pl;
  } m_ent_t;

  m_ent_t model_q[$];
  logic [W-1:0] exp_q[$];

  issue_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_payload(alloc_payload),
    .alloc_rd_rob_idx(alloc_rd_rob_idx),
    .alloc_rs1_ready(alloc_rs1_ready), .alloc_rs1_data(alloc_rs1_data), .alloc_rs1_rob_idx(alloc_rs1_rob_idx),
    .alloc_rs2_ready(alloc_rs2_ready), .alloc_rs2_data(alloc_rs2_data), .alloc_rs2_rob_idx(alloc_rs2_rob_idx),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_payload(issue_payload),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .issue_rd_rob_idx(issue_rd_rob_idx), .occupancy(occupancy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lowest-index valid channel carrying tag.
  function automatic bit snoop(input logic [RW-1:0] tag, output logic [DW-1:0] d);
    for (int c = 0; c < NC; c++) begin
      if (cdb_valid[c] && cdb_rob_idx[c*RW +: RW] == tag) begin
        d = cdb_data[c*DW +: DW];
        return 1'b1;
      end
    end
    d = '0;
    return 1'b0;
  endfunction

  // Reference model: list in allocation order; checks and next state each cycle.
  always @(negedge clk) begin
    int sel;
    int n0;
    m_ent_t e, exp_e;
    logic [DW-1:0] d;
    sel = -1;
    exp_e = '{default: '0};
    if (!rst && !flush) begin
      for (int i = 0; i < model_q.size(); i++) begin
        e = model_q[i];
        if (BYP && !e.r1 && snoop(e.t1, d)) begin e.r1 = 1'b1; e.d1 = d; end
        if (BYP && !e.r2 && snoop(e.t2, d)) begin e.r2 = 1'b1; e.d2 = d; end
        if (e.r1 && e.r2) begin sel = i; exp_e = e; break; end
      end
    end
    check("occupancy", 128'(occupancy), 128'(model_q.size()));
    check("alloc_ready", 128'(alloc_ready), 128'(model_q.size() < DEPTH));
    check("issue_valid", 128'(issue_valid), 128'(sel >= 0));
    if (sel >= 0 && issue_ready) exp_q.push_back({exp_e.pl, exp_e.d1, exp_e.d2, exp_e.rd});
    if (rst || flush) begin
      model_q.delete();
    end else begin
      n0 = model_q.size();
      if (sel >= 0 && issue_ready) model_q.delete(sel);
      for (int i = 0; i < model_q.size(); i++) begin
        e = model_q[i];
        if (!e.r1 && snoop(e.t1, d)) begin e.r1 = 1'b1; e.d1 = d; end
        if (!e.r2 && snoop(e.t2, d)) begin e.r2 = 1'b1; e.d2 = d; end
        model_q[i] = e;
      end
      if (alloc_valid && n0 < DEPTH) begin
        e.pl = alloc_payload; e.rd = alloc_rd_rob_idx;
        e.t1 = alloc_rs1_rob_idx; e.t2 = alloc_rs2_rob_idx;
        e.r1 = alloc_rs1_ready; e.d1 = alloc_rs1_data;
        e.r2 = alloc_rs2_ready; e.d2 = alloc_rs2_data;
        if (!e.r1 && snoop(e.t1, d)) begin e.r1 = 1'b1; e.d1 = d; end
        if (!e.r2 && snoop(e.t2, d)) begin e.r2 = 1'b1; e.d2 = d; end
        model_q.push_back(e);
      end
    end
  end

  // Monitor: every accepted issue must match the scoreboard head.
  always @(negedge clk) begin
    logic [W-1:0] w;
    #1;
    if (issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        check("issue_unexpected", 128'(1), 128'(0));
      end else begin
        w = exp_q.pop_front();
        check("issue_payload", 128'(issue_payload), 128'(w[W-1 -: PW]));
        check("issue_rs1", 128'(issue_rs1_data), 128'(w[DW+DW+RW-1 -: DW]));
        check("issue_rs2", 128'(issue_rs2_data), 128'(w[DW+RW-1 -: DW]));
        check("issue_rd", 128'(issue_rd_rob_idx), 128'(w[RW-1:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0; flush = 1'b0; cdb_valid = '0;
  endtask

  task automatic set_alloc(input bit r1, input logic [DW-1:0] d1, input logic [RW-1:0] t1,
                           input bit r2, input logic [DW-1:0] d2, input logic [RW-1:0] t2,
                           input logic [RW-1:0] rd);
    alloc_valid = 1'b1;
    alloc_payload = {$urandom(), $urandom(), $urandom()};
    alloc_rs1_ready = r1; alloc_rs1_data = d1; alloc_rs1_rob_idx = t1;
    alloc_rs2_ready = r2; alloc_rs2_data = d2; alloc_rs2_rob_idx = t2;
    alloc_rd_rob_idx = rd;
  endtask

  task automatic do_alloc(input bit r1, input logic [DW-1:0] d1, input logic [RW-1:0] t1,
                          input bit r2, input logic [DW-1:0] d2, input logic [RW-1:0] t2,
                          input logic [RW-1:0] rd);
    set_alloc(r1, d1, t1, r2, d2, t2, rd);
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic fill_ready(input int n, input int base);
    for (int i = 0; i < n; i++) do_alloc(1'b1, 32'(base + i), 5'd0, 1'b1, 32'(base + 100 + i), 5'd0, 5'(base + i));
  endtask

  task automatic cdb_send(input int ch, input logic [RW-1:0] tag, input logic [DW-1:0] data);
    cdb_valid[ch] = 1'b1;
    cdb_rob_idx[ch*RW +: RW] = tag;
    cdb_data[ch*DW +: DW] = data;
  endtask

  initial begin
    rst = 1'b1; issue_ready = 1'b0; cdb_rob_idx = '0; cdb_data = '0;
    set_alloc(1'b0, '0, '0, 1'b0, '0, '0, '0);
    idle();
    repeat (3) tick();
    rst = 1'b0;
    // 1: CDB traffic on an empty queue
    for (int k = 0; k < 3; k++) begin
      cdb_send(k, 5'(k + 1), 32'(k * 17));
      tick();
    end
    idle();
    check("reset_occupancy", 128'(occupancy), 128'(0));
    check("reset_issue_valid", 128'(issue_valid), 128'(0));
    // 2: ready alloc issues the next cycle
    issue_ready = 1'b1;
    do_alloc(1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0, 5'd3);
    check("t2_issue_valid", 128'(issue_valid), 128'(1));
    check("t2_rs1", 128'(issue_rs1_data), 128'(5));
    check("t2_rs2", 128'(issue_rs2_data), 128'(7));
    check("t2_rd", 128'(issue_rd_rob_idx), 128'(3));
    tick();
    check("t2_occupancy", 128'(occupancy), 128'(0));
    // 3: B waits on tag 9, C is ready and issues first
    do_alloc(1'b0, 32'd0, 5'd9, 1'b1, 32'd1, 5'd0, 5'd4);
    do_alloc(1'b1, 32'd2, 5'd0, 1'b1, 32'd3, 5'd0, 5'd5);
    tick();
    cdb_send(2, 5'd9, 32'hABCD);
    tick();
    idle();
    repeat (2) tick();
    // 4: slots reused out of index order; issue follows allocation order
    issue_ready = 1'b0;
    fill_ready(4, 10);
    issue_ready = 1'b1;
    repeat (2) tick();
    issue_ready = 1'b0;
    fill_ready(2, 20);
    issue_ready = 1'b1;
    repeat (6) tick();
    // 5: full queue, issue while alloc is held
    issue_ready = 1'b0;
    fill_ready(4, 30);
    set_alloc(1'b1, 32'd77, 5'd0, 1'b1, 32'd78, 5'd0, 5'd7);
    issue_ready = 1'b1;
    check("t5_full_alloc_ready", 128'(alloc_ready), 128'(0));
    tick();
    issue_ready = 1'b0;
    tick();
    alloc_valid = 1'b0;
    check("t5_occupancy", 128'(occupancy), 128'(4));
    issue_ready = 1'b1;
    repeat (6) tick();
    // 6: flush with concurrent alloc
    issue_ready = 1'b0;
    fill_ready(3, 40);
    issue_ready = 1'b1;
    flush = 1'b1;
    set_alloc(1'b1, 32'd9, 5'd0, 1'b1, 32'd9, 5'd0, 5'd9);
    #1;
    check("t6_flush_issue_valid", 128'(issue_valid), 128'(0));
    tick();
    idle();
    check("t6_occupancy", 128'(occupancy), 128'(0));
    repeat (2) tick();
    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      set_alloc(1'($urandom_range(0, 1)), $urandom(), 5'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), $urandom(), 5'($urandom_range(0, 15)),
                5'($urandom_range(0, 31)));
      alloc_valid = ($urandom_range(0, 1) == 1);
      issue_ready = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < NC; c++) begin
        cdb_valid[c] = ($urandom_range(0, 9) < 3);
        cdb_rob_idx[c*RW +: RW] = 5'($urandom_range(0, 15));
        cdb_data[c*DW +: DW] = $urandom();
      end
      flush = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
